// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer-side write handshake for the UART transmitter FIFO
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_valid;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO, configurable frame format
module uart_tx_fifo #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    uart_tx_fifo_if.slave                   wr,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            tx_busy,
    output logic                            txd
);
    localparam int T  = 2 * CLK_PER_HALF_BIT;
    localparam int TW = (T > 2) ? $clog2(T) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nx;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr, wr_ptr;
    logic [AW:0]          count;
    logic [TW-1:0]        bit_cnt;
    logic [DW-1:0]        data_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shifter;
    logic                 par_bit;
    logic                 txd_r;
    logic                 push, pop, bit_end;
    logic [DATA_BITS-1:0] head;

    assign head       = mem[rd_ptr];
    assign bit_end    = (bit_cnt == TW'(T - 1));
    assign wr.wr_ready = (count != (AW+1)'(FIFO_DEPTH));
    assign push       = wr.wr_valid && wr.wr_ready;
    assign fifo_count = count;
    assign tx_busy    = (state != IDLE) || (count != '0);
    assign txd        = txd_r;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // A pop is only ever taken when the line is free: from IDLE, or on the
    // last clock of the final stop bit so the next start bit follows with no gap.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                pop      = 1'b1;
                state_nx = START;
            end
            START: if (bit_end) state_nx = DATA;
            DATA: if (bit_end && data_idx == DW'(DATA_BITS - 1))
                state_nx = (PARITY != 0) ? PAR : STOP;
            PAR: if (bit_end) state_nx = STOP;
            STOP: if (bit_end && stop_idx == 1'(STOP_BITS - 1)) begin
                if (count != '0) begin
                    pop      = 1'b1;
                    state_nx = START;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txd_r    <= 1'b1;
            bit_cnt  <= '0;
            data_idx <= '0;
            stop_idx <= 1'b0;
            shifter  <= '0;
            par_bit  <= 1'b0;
        end else if (pop) begin
            shifter  <= head;
            par_bit  <= (PARITY == 1) ? ~^head : ^head;
            txd_r    <= 1'b0;
            bit_cnt  <= '0;
            data_idx <= '0;
            stop_idx <= 1'b0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                bit_cnt <= '0;
                case (state)
                    START: begin
                        txd_r   <= shifter[0];
                        shifter <= shifter >> 1;
                    end
                    DATA: if (data_idx == DW'(DATA_BITS - 1)) begin
                        txd_r <= (PARITY != 0) ? par_bit : 1'b1;
                    end else begin
                        data_idx <= data_idx + 1'b1;
                        txd_r    <= shifter[0];
                        shifter  <= shifter >> 1;
                    end
                    PAR:  txd_r <= 1'b1;
                    STOP: begin
                        stop_idx <= stop_idx + 1'b1;
                        txd_r    <= 1'b1;
                    end
                    default: txd_r <= 1'b1;
                endcase
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end
endmodule
